// File: rtl/crossbar_2x2_sched_pkg.sv
// Shared definitions for the 2x2 crossbar scheduler.
//   XBAR_STRAIGHT / XBAR_CROSS : crossbar control encodings
//   IDLE / ACTIVE / DRAIN      : scheduler FSM state encodings
//   word_t                     : crossbar payload word
//   route_ctrl()               : crossbar control needed to route one request
package crossbar_2x2_sched_pkg;

    localparam logic XBAR_STRAIGHT = 1'b0;
    localparam logic XBAR_CROSS    = 1'b1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    typedef logic [3:0] word_t;

    // in1 reaches out(dest+1) straight when dest=0; in2 reaches out2 straight when dest=1.
    function automatic logic route_ctrl(input logic dest, input logic from_in2);
        return from_in2 ? ~dest : dest;
    endfunction

endpackage

// File: rtl/crossbar_2x2_sched_cell.sv
// 4-bit 2x2 crossbar cell.
//   in1, in2   : input words
//   control    : XBAR_STRAIGHT (in1->1, in2->2) or XBAR_CROSS (in1->2, in2->1)
//   out1_a/2_a : switched words
//   out1_b/2_b : words not routed to the matching "a" port
module crossbar_2x2_sched_cell
    import crossbar_2x2_sched_pkg::*;
(
    input  word_t in1,
    input  word_t in2,
    input  logic  control,
    output word_t out1_a,
    output word_t out2_a,
    output word_t out1_b,
    output word_t out2_b
);

    always_comb begin
        if (control == XBAR_CROSS) begin
            out1_a = in2;
            out2_a = in1;
            out1_b = in1;
            out2_b = in2;
        end else begin
            out1_a = in1;
            out2_a = in2;
            out1_b = in2;
            out2_b = in1;
        end
    end

endmodule

// File: rtl/crossbar_2x2_sched.sv
// Scheduler/arbiter sharing a 2x2 crossbar cell between two valid/ready requesters.
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : 1 = accept traffic, 0 = stop accepting and drain
//   inK_valid/dest/data      : requester K word and destination (0 = out1, 1 = out2)
//   inK_ready                : requester K word accepted this cycle
//   outK_valid/data/ready    : one-entry output buffer K with sink backpressure
//   xbar_control             : crossbar control this cycle (0 straight, 1 cross)
//   prio                     : round-robin pointer (0 = in1 wins the next conflict)
//   conflict_cnt             : saturating count of granted conflict cycles
//   busy                     : FSM not idle
module crossbar_2x2_sched
    import crossbar_2x2_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in1_valid,
    input  logic             in1_dest,
    input  logic [3:0]       in1_data,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic             in2_dest,
    input  logic [3:0]       in2_data,
    output logic             in2_ready,
    output logic             out1_valid,
    output logic [3:0]       out1_data,
    input  logic             out1_ready,
    output logic             out2_valid,
    output logic [3:0]       out2_data,
    input  logic             out2_ready,
    output logic             xbar_control,
    output logic             prio,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic             busy
);

    logic [1:0]       state_q, state_d;
    logic             out1_valid_q, out1_valid_d;
    logic             out2_valid_q, out2_valid_d;
    word_t            out1_data_q, out1_data_d;
    word_t            out2_data_q, out2_data_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic  free1, free2, free_t1, free_t2;
    logic  accepting, conflict;
    logic  grant1, grant2;
    logic  wr1, wr2;
    logic  ctrl;
    word_t xa1, xa2;
    word_t unused_b1, unused_b2;

    // A buffer can take a word if empty or being drained this same cycle.
    assign free1   = !out1_valid_q || out1_ready;
    assign free2   = !out2_valid_q || out2_ready;
    assign free_t1 = in1_dest ? free2 : free1;
    assign free_t2 = in2_dest ? free2 : free1;

    assign accepting = (state_q == ACTIVE) && en;
    assign conflict  = in1_valid && in2_valid && (in1_dest == in2_dest);

    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (accepting) begin
            if (conflict) begin
                if (!prio_q) grant1 = free_t1;
                else         grant2 = free_t2;
            end else begin
                grant1 = in1_valid && free_t1;
                grant2 = in2_valid && free_t2;
            end
        end
    end

    // With both granted the destinations differ, so both requests imply the same control.
    always_comb begin
        ctrl = XBAR_STRAIGHT;
        if (grant1)      ctrl = route_ctrl(in1_dest, 1'b0);
        else if (grant2) ctrl = route_ctrl(in2_dest, 1'b1);
    end

    crossbar_2x2_sched_cell u_cell (
        .in1     (in1_data),
        .in2     (in2_data),
        .control (ctrl),
        .out1_a  (xa1),
        .out2_a  (xa2),
        .out1_b  (unused_b1),
        .out2_b  (unused_b2)
    );

    assign wr1 = (grant1 && !in1_dest) || (grant2 && !in2_dest);
    assign wr2 = (grant1 && in1_dest)  || (grant2 && in2_dest);

    always_comb begin
        out1_valid_d = out1_valid_q;
        out1_data_d  = out1_data_q;
        out2_valid_d = out2_valid_q;
        out2_data_d  = out2_data_q;
        if (wr1) begin
            out1_valid_d = 1'b1;
            out1_data_d  = xa1;
        end else if (out1_ready) begin
            out1_valid_d = 1'b0;
        end
        if (wr2) begin
            out2_valid_d = 1'b1;
            out2_data_d  = xa2;
        end else if (out2_ready) begin
            out2_valid_d = 1'b0;
        end
    end

    // Pointer moves to the loser only when a conflict actually produced a grant.
    always_comb begin
        prio_d = prio_q;
        cnt_d  = cnt_q;
        if (conflict && (grant1 || grant2)) begin
            prio_d = ~prio_q;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = ACTIVE;
            ACTIVE:  if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en)                                state_d = ACTIVE;
                else if (!out1_valid_d && !out2_valid_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out1_valid_q <= 1'b0;
            out2_valid_q <= 1'b0;
            out1_data_q  <= '0;
            out2_data_q  <= '0;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            out1_valid_q <= out1_valid_d;
            out2_valid_q <= out2_valid_d;
            out1_data_q  <= out1_data_d;
            out2_data_q  <= out2_data_d;
            prio_q       <= prio_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in1_ready    = grant1;
    assign in2_ready    = grant2;
    assign out1_valid   = out1_valid_q;
    assign out1_data    = out1_data_q;
    assign out2_valid   = out2_valid_q;
    assign out2_data    = out2_data_q;
    assign xbar_control = ctrl;
    assign prio         = prio_q;
    assign conflict_cnt = cnt_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_crossbar_2x2_sched.sv
// Directed, table-driven bench for crossbar_2x2_sched. A second instance with
// CNT_W=2 shares all inputs so counter saturation is observed on the same traffic.
module tb_crossbar_2x2_sched;

    logic       clk = 1'b0;
    logic       rst, en;
    logic       in1_valid, in1_dest, in2_valid, in2_dest;
    logic [3:0] in1_data, in2_data;
    logic       out1_ready, out2_ready;

    logic       in1_ready, in2_ready, out1_valid, out2_valid, xbar_control, prio, busy;
    logic [3:0] out1_data, out2_data;
    logic [7:0] conflict_cnt;

    logic       s_in1_ready, s_in2_ready, s_out1_valid, s_out2_valid, s_xbar, s_prio, s_busy;
    logic [3:0] s_out1_data, s_out2_data;
    logic [1:0] s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crossbar_2x2_sched #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in1_valid(in1_valid), .in1_dest(in1_dest), .in1_data(in1_data), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_dest(in2_dest), .in2_data(in2_data), .in2_ready(in2_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
        .out2_valid(out2_valid), .out2_data(out2_data), .out2_ready(out2_ready),
        .xbar_control(xbar_control), .prio(prio), .conflict_cnt(conflict_cnt), .busy(busy)
    );

    crossbar_2x2_sched #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en),
        .in1_valid(in1_valid), .in1_dest(in1_dest), .in1_data(in1_data), .in1_ready(s_in1_ready),
        .in2_valid(in2_valid), .in2_dest(in2_dest), .in2_data(in2_data), .in2_ready(s_in2_ready),
        .out1_valid(s_out1_valid), .out1_data(s_out1_data), .out1_ready(out1_ready),
        .out2_valid(s_out2_valid), .out2_data(s_out2_data), .out2_ready(out2_ready),
        .xbar_control(s_xbar), .prio(s_prio), .conflict_cnt(s_cnt), .busy(s_busy)
    );

    typedef struct {
        logic       en, v1, d1;
        logic [3:0] x1;
        logic       v2, d2;
        logic [3:0] x2;
        logic       r1, r2;
        logic       g1, g2, xc;
        logic       ov1;
        logic [3:0] od1;
        logic       ov2;
        logic [3:0] od2;
        logic       prio;
        logic [7:0] cnt;
        logic [1:0] scnt;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en_, v1, d1, input logic [3:0] x1, input logic v2, d2,
                       input logic [3:0] x2, input logic r1, r2, g1, g2, xc, ov1,
                       input logic [3:0] od1, input logic ov2, input logic [3:0] od2,
                       input logic pr, input logic [7:0] cnt, input logic [1:0] scnt,
                       input logic bsy);
        vec_t v;
        v.en = en_; v.v1 = v1; v.d1 = d1; v.x1 = x1; v.v2 = v2; v.d2 = d2; v.x2 = x2;
        v.r1 = r1; v.r2 = r2; v.g1 = g1; v.g2 = g2; v.xc = xc; v.ov1 = ov1; v.od1 = od1;
        v.ov2 = ov2; v.od2 = od2; v.prio = pr; v.cnt = cnt; v.scnt = scnt; v.busy = bsy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en_, v1, d1, input logic [3:0] x1, input logic v2, d2,
                         input logic [3:0] x2, input logic r1, r2);
        en = en_; in1_valid = v1; in1_dest = d1; in1_data = x1;
        in2_valid = v2; in2_dest = d2; in2_data = x2; out1_ready = r1; out2_ready = r2;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset in1_ready", in1_ready, 0);
        check("reset out1_valid", out1_valid, 0);
        check("reset out2_valid", out2_valid, 0);
        check("reset out1_data", out1_data, 0);
        check("reset out2_data", out2_data, 0);
        check("reset prio", prio, 0);
        check("reset cnt", conflict_cnt, 0);
        check("reset busy", busy, 0);

        //   en v1 d1 x1    v2 d2 x2    r1 r2 | g1 g2 xc ov1 od1  ov2 od2  pr cnt scnt busy
        add(1, 0, 0, 4'h0, 0, 0, 4'h0, 1, 1,  0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1);
        add(1, 1, 0, 4'hA, 1, 1, 4'h5, 1, 1,  1, 1, 0, 1, 4'hA, 1, 4'h5, 0, 0, 0, 1);
        add(1, 1, 1, 4'h3, 1, 0, 4'hC, 1, 1,  1, 1, 1, 1, 4'hC, 1, 4'h3, 0, 0, 0, 1);
        // sustained conflict to out1, alternating winners
        add(1, 1, 0, 4'h1, 1, 0, 4'h2, 1, 1,  1, 0, 0, 1, 4'h1, 0, 4'h3, 1, 1, 1, 1);
        add(1, 1, 0, 4'h1, 1, 0, 4'h2, 1, 1,  0, 1, 1, 1, 4'h2, 0, 4'h3, 0, 2, 2, 1);
        add(1, 1, 0, 4'h1, 1, 0, 4'h2, 1, 1,  1, 0, 0, 1, 4'h1, 0, 4'h3, 1, 3, 3, 1);
        add(1, 1, 0, 4'h1, 1, 0, 4'h2, 1, 1,  0, 1, 1, 1, 4'h2, 0, 4'h3, 0, 4, 3, 1);
        add(1, 1, 0, 4'h1, 1, 0, 4'h2, 1, 1,  1, 0, 0, 1, 4'h1, 0, 4'h3, 1, 5, 3, 1);
        // conflict with target full: no grant, prio and count hold
        add(1, 1, 0, 4'h1, 1, 0, 4'h2, 0, 1,  0, 0, 0, 1, 4'h1, 0, 4'h3, 1, 5, 3, 1);
        // backpressure then same-cycle drain-and-refill
        add(1, 1, 0, 4'h7, 0, 0, 4'h0, 0, 1,  0, 0, 0, 1, 4'h1, 0, 4'h3, 1, 5, 3, 1);
        add(1, 1, 0, 4'h7, 0, 0, 4'h0, 1, 1,  1, 0, 0, 1, 4'h7, 0, 4'h3, 1, 5, 3, 1);
        // lone in2 to out1 needs cross
        add(1, 0, 0, 4'h0, 1, 0, 4'h9, 1, 1,  0, 1, 1, 1, 4'h9, 0, 4'h3, 1, 5, 3, 1);
        // distinct destinations, in1 stalls while in2 proceeds
        add(1, 1, 0, 4'hB, 1, 1, 4'h6, 0, 1,  0, 1, 0, 1, 4'h9, 1, 4'h6, 1, 5, 3, 1);
        // drain: en low blocks grants, exit once out1 empties
        add(0, 1, 0, 4'hB, 0, 0, 4'h0, 0, 1,  0, 0, 0, 1, 4'h9, 0, 4'h6, 1, 5, 3, 1);
        add(0, 1, 0, 4'hB, 0, 0, 4'h0, 0, 0,  0, 0, 0, 1, 4'h9, 0, 4'h6, 1, 5, 3, 1);
        add(0, 1, 0, 4'hB, 0, 0, 4'h0, 1, 0,  0, 0, 0, 0, 4'h9, 0, 4'h6, 1, 5, 3, 0);
        add(0, 1, 0, 4'hB, 0, 0, 4'h0, 1, 1,  0, 0, 0, 0, 4'h9, 0, 4'h6, 1, 5, 3, 0);
        // re-enable: idle cycle grants nothing, then traffic resumes
        add(1, 1, 0, 4'hB, 0, 0, 4'h0, 1, 1,  0, 0, 0, 0, 4'h9, 0, 4'h6, 1, 5, 3, 1);
        add(1, 1, 0, 4'hB, 0, 0, 4'h0, 1, 1,  1, 0, 0, 1, 4'hB, 0, 4'h6, 1, 5, 3, 1);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            drive(v.en, v.v1, v.d1, v.x1, v.v2, v.d2, v.x2, v.r1, v.r2);
            #1;
            check($sformatf("row%0d in1_ready", i), in1_ready, v.g1);
            check($sformatf("row%0d in2_ready", i), in2_ready, v.g2);
            check($sformatf("row%0d xbar_control", i), xbar_control, v.xc);
            @(posedge clk);
            #1;
            check($sformatf("row%0d out1_valid", i), out1_valid, v.ov1);
            check($sformatf("row%0d out1_data", i), out1_data, v.od1);
            check($sformatf("row%0d out2_valid", i), out2_valid, v.ov2);
            check($sformatf("row%0d out2_data", i), out2_data, v.od2);
            check($sformatf("row%0d prio", i), prio, v.prio);
            check($sformatf("row%0d conflict_cnt", i), conflict_cnt, v.cnt);
            check($sformatf("row%0d sat_cnt", i), s_cnt, v.scnt);
            check($sformatf("row%0d busy", i), busy, v.busy);
        end

        // Fill out2 while out1 (0xB) is held, then reset with a conflict pending.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("prefill out1_valid", out1_valid, 1);
        check("prefill out2_valid", out2_valid, 1);
        check("prefill out2_data", out2_data, 4'h4);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 4'hD, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst out1_valid", out1_valid, 0);
        check("rst out2_valid", out2_valid, 0);
        check("rst out1_data", out1_data, 0);
        check("rst prio", prio, 0);
        check("rst conflict_cnt", conflict_cnt, 0);
        check("rst sat_cnt", s_cnt, 0);
        check("rst busy", busy, 0);
        check("rst in1_ready", in1_ready, 0);
        check("rst in2_ready", in2_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crossbar_2x2_sched.md
Name: crossbar_2x2_sched

Overview:
Scheduler and arbiter that shares the 4-bit 2x2 crossbar cell between two valid/ready requesters, each carrying a 1-bit destination. Each cycle it picks the crossbar control (straight or cross) and grants the non-conflicting requests. It registers the switched data into one-entry output buffers with valid/ready backpressure. Enable/drain sequencing is handled by a small FSM.

Parameters:
CNT_W, 8, width of the saturating conflict counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  enable; 1 = accept traffic, 0 = stop accepting and drain
in1_valid  in  1  requester 1 has a word
in1_dest  in  1  destination of requester 1 (0 = out1, 1 = out2)
in1_data  in  4  requester 1 payload
in1_ready  out  1  requester 1 word accepted this cycle
in2_valid, in2_dest, in2_data, in2_ready  same as requester 1, for requester 2
out1_valid  out  1  output buffer 1 holds a word
out1_data  out  4  output buffer 1 payload
out1_ready  in  1  sink 1 consumes this cycle
out2_valid, out2_data, out2_ready  same as output 1, for output 2
xbar_control  out  1  crossbar control this cycle (0 = straight in1->out1/in2->out2, 1 = cross)
prio  out  1  round-robin pointer (0 = in1 wins the next conflict)
conflict_cnt  out  CNT_W  saturating count of conflict cycles
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE, out1/out2_valid=0, out1/out2_data=0, prio=0, conflict_cnt=0.
  - Reset mid-transfer discards buffered words.
- FSM:
  - IDLE: no grants. en=1 -> ACTIVE.
  - ACTIVE: grants per the rules below. en=0 -> DRAIN; no grants are issued in the cycle en is low.
  - DRAIN: no grants. Exits when both out valids will be 0 after this edge: en=1 -> ACTIVE, else -> IDLE. If en=1 while still draining -> ACTIVE.
- free_k = !outk_valid || outk_ready. Same-cycle drain-and-refill is allowed.
- Grant rules (ACTIVE only; all combinational from the current inputs and state):
  - Different destinations, both valid: each granted iff its target buffer is free. Grants are independent, so one may stall while the other proceeds.
  - Same destination, both valid (conflict): only the prio winner can be granted, and only if the target is free.
    - When a conflict grant issues: prio flips to the loser and conflict_cnt increments, saturating at all ones.
    - When the target is not free: no grant, prio unchanged, no count.
  - Single valid: granted iff its target is free; prio unchanged.
- xbar_control:
  - in1 granted: control = in1_dest.
  - Else if in2 granted: control = ~in2_dest.
  - Else: 0.
  - When both are granted, the destinations differ, so the two requests agree on control.
- inK_ready = grantK.
  - Requesters must hold valid/dest/data stable until ready; valid must not depend on ready.
- Output buffers, per output k:
  - Granted word to k: outk_data <= the crossbar's "a" output for port k; outk_valid <= 1.
  - Else if outk_ready: outk_valid <= 0 (data holds).
- Latency: input accepted at edge N appears on outk_data/outk_valid after edge N; 1 cycle.
- Throughput: 2 words/cycle with distinct destinations; 1 word/cycle under sustained conflict, alternating requesters.
- out_ready with out_valid=0 has no effect.

Decomposition:
- Shared package:
  - constants XBAR_STRAIGHT=0 and XBAR_CROSS=1
  - FSM state encoding IDLE=2'd0, ACTIVE=2'd1, DRAIN=2'd2
- Sub-module: the existing 4-bit 2x2 crossbar cell, instantiated once and driven by xbar_control; its "b" outputs are left unconnected.
- Arbitration and the FSM stay inline.

Test Plan:
- Reset then en=1; in1(dest0,0xA) and in2(dest1,0x5) in the same cycle -> both ready=1, xbar_control=0; next cycle out1=0xA, out2=0x5, both valid.
- in1(dest1,0x3) and in2(dest0,0xC), sinks ready -> xbar_control=1; out2=0x3, out1=0xC after 1 cycle; conflict_cnt stays 0.
- Both dest0, data 0x1/0x2, held for 4 cycles, out1_ready=1 -> out1 sequence 0x1,0x2,0x1,0x2; prio toggles each cycle; conflict_cnt=4. With CNT_W=2 over 5 conflicts -> saturates at 3.
- out1_ready=0 with out1 full, in1(dest0) valid -> in1_ready=0 and out1 data held. Raise out1_ready -> grant in the same cycle and new data next cycle.
- Drain: out1 full and out1_ready=0, drop en -> state DRAIN, no grants, busy=1. Raise out1_ready -> IDLE next cycle, busy=0.
- Assert rst while both out buffers are valid and a conflict is pending -> next cycle all valids=0, prio=0, conflict_cnt=0, state IDLE, all in_ready=0.
